// File: rtl/prog_inst_mem_pkg.sv
// Shared types and constants for the program instruction memory.
package prog_inst_mem_pkg;

  // Controller states: FILL writes the NOP word, RUN serves fetches, LOAD accepts program words
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  // Why a fetch faulted
  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_RANGE    = 2'd2
  } fault_e;

  // addi x0,x0,0 -- used as fill pattern and as the faulted / idle fetch value
  localparam logic [31:0] NOP_WORD_RV = 32'h0000_0013;

endpackage

// File: rtl/inst_ram_1r1w.sv
// DEPTH x DATA_W storage, one write port and one registered read port, no reset.
module inst_ram_1r1w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array contents are only ever defined by the controller's fill/load writes
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_inst_mem.sv
// Program instruction memory: NOP fill after reset, host program load, 1-cycle fetch port.
module prog_inst_mem #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        DEPTH    = 64,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(prog_inst_mem_pkg::NOP_WORD_RV)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc,
  input  logic              fetch_req,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy
);
  import prog_inst_mem_pkg::*;

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_e            state_q;
  logic [AW-1:0]     fill_ptr_q, ld_ptr_q;
  logic              fill_from_ld_q;   // current FILL finishes a program load
  logic              ld_done_q;
  logic              fetch_valid_q, fetch_fault_q;

  logic              run, fetch_go;
  fault_e            fault_rsn;
  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign run      = (state_q == ST_RUN);
  assign fetch_go = run && fetch_req;

  // Classify the requested pc; misalignment takes precedence over range
  always_comb begin
    fault_rsn = FLT_NONE;
    if (|pc[1:0])            fault_rsn = FLT_MISALIGN;
    else if (|pc[31:AW+2])   fault_rsn = FLT_RANGE;
  end

  // Single write port arbitration: FILL writes NOP, LOAD writes host data
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = fill_ptr_q;
    ram_wdata = NOP_WORD;
    unique case (state_q)
      ST_FILL: ram_we = 1'b1;
      ST_LOAD: begin
        ram_we    = ld_valid;
        ram_waddr = ld_ptr_q;
        ram_wdata = ld_data;
      end
      default: ;
    endcase
  end

  assign ram_re = fetch_go && (fault_rsn == FLT_NONE);

  inst_ram_1r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (pc[AW+1:2]),
    .rdata_o (ram_rdata)
  );

  // Controller FSM: fill sweep, program load, and the one-cycle load-complete pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FILL;
      fill_ptr_q     <= '0;
      ld_ptr_q       <= '0;
      fill_from_ld_q <= 1'b0;
      ld_done_q      <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      unique case (state_q)
        ST_FILL: begin
          fill_ptr_q <= fill_ptr_q + PTR_ONE;
          if (fill_ptr_q == PTR_LAST) begin
            state_q        <= ST_RUN;
            ld_done_q      <= fill_from_ld_q;
            fill_from_ld_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (ld_start) begin
            state_q  <= ST_LOAD;
            ld_ptr_q <= '0;
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            ld_ptr_q <= ld_ptr_q + PTR_ONE;
            if (ld_ptr_q == PTR_LAST) begin
              // array is full: nothing left to fill
              state_q   <= ST_RUN;
              ld_done_q <= 1'b1;
            end else if (ld_last) begin
              state_q        <= ST_FILL;
              fill_ptr_q     <= ld_ptr_q + PTR_ONE;
              fill_from_ld_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  // Fetch response flags, one cycle behind the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_go;
      fetch_fault_q <= fetch_go && (fault_rsn != FLT_NONE);
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign fetch_instr = (fetch_valid_q && !fetch_fault_q) ? ram_rdata : NOP_WORD;
  assign ld_ready    = (state_q == ST_LOAD);
  assign ld_done     = ld_done_q;
  assign busy        = !run;

endmodule

// File: tb/tb_prog_inst_mem.sv
// Self-checking bench for prog_inst_mem: directed tables plus randomized loads/fetches vs a word-array model.
module tb_prog_inst_mem;
  localparam int          DW    = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pc;
  logic          fetch_req, ld_start, ld_valid, ld_last;
  logic [DW-1:0] ld_data;
  logic          fetch_valid, fetch_fault, ld_ready, ld_done, busy;
  logic [DW-1:0] fetch_instr;

  prog_inst_mem #(.DATA_W(DW), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_req(fetch_req),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [DEPTH];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference: a word-indexed array; anything misaligned or beyond the array faults
  task automatic model_fetch(input logic [31:0] a, output logic [31:0] ins, output logic flt);
    flt = (a % 4 != 0) || ((a / 4) >= DEPTH);
    ins = flt ? NOP : mdl[a / 4];
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef, input string nm);
    fetch_req = 1'b1; pc = a;
    step();
    fetch_req = 1'b0;
    chk({nm, "_valid"}, fetch_valid, 1);
    chk({nm, "_instr"}, fetch_instr, ei);
    chk({nm, "_fault"}, fetch_fault, ef);
  endtask

  task automatic model_check(input logic [31:0] a, input string nm);
    logic [31:0] ei; logic ef;
    model_fetch(a, ei, ef);
    do_fetch(a, ei, ef, nm);
  endtask

  task automatic verify_all(input string nm);
    for (int i = 0; i < DEPTH; i++) model_check(32'(i * 4), nm);
  endtask

  task automatic do_reset(input string nm);
    int n; bit seen;
    fetch_req = 0; ld_start = 0; ld_valid = 0; ld_last = 0;
    rst_n = 1'b0; #1;
    chk({nm, "_rst_busy"},  busy, 1);
    chk({nm, "_rst_ready"}, ld_ready, 0);
    chk({nm, "_rst_done"},  ld_done, 0);
    chk({nm, "_rst_fvld"},  fetch_valid, 0);
    chk({nm, "_rst_fflt"},  fetch_fault, 0);
    chk({nm, "_rst_finst"}, fetch_instr, NOP);
    step(); step();
    rst_n = 1'b1;
    n = 0; seen = 0;
    while (busy && n < 4 * DEPTH) begin
      step(); n++;
      if (ld_done) seen = 1;
    end
    chk({nm, "_fill_cycles"}, n, DEPTH);
    chk({nm, "_no_done"}, 32'(seen), 0);
    for (int i = 0; i < DEPTH; i++) mdl[i] = NOP;
  endtask

  task automatic load(input logic [31:0] ws[$], input bit use_last, input int extra,
                      input bit bubbles, input string nm);
    int n, nw, expw;
    n = ws.size();
    ld_start = 1'b1; step(); ld_start = 1'b0;
    chk({nm, "_ready"}, ld_ready, 1);
    for (int i = 0; i < n; i++) begin
      if (bubbles) repeat ($urandom_range(0, 2)) step();
      ld_valid = 1'b1; ld_data = ws[i]; ld_last = use_last && (i == n - 1);
      step();
      ld_valid = 1'b0; ld_last = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) mdl[i] = (i < n) ? ws[i] : NOP;
    expw = (n < DEPTH) ? DEPTH - n : 0;
    nw = 0;
    while (!ld_done && nw < 4 * DEPTH) begin step(); nw++; end
    chk({nm, "_done_wait"}, nw, expw);
    chk({nm, "_done"}, ld_done, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_ready_off"}, ld_ready, 0);
    for (int k = 0; k < ((extra > 0) ? extra : 1); k++) begin
      ld_valid = (extra > 0); ld_data = $urandom;
      step();
      chk({nm, "_done_pulse"}, ld_done, 0);
      chk({nm, "_no_accept"}, ld_ready, 0);
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ws [$];
    logic [31:0] a;
    int r, idx, n;
    pc = 0; fetch_req = 0; ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = 0;
    rst_n = 1'b1;
    #2;
    do_reset("por");

    // First fetch after power-on fill, then an idle cycle must not report valid
    do_fetch(32'h0, NOP, 1'b0, "por_pc0");
    step();
    chk("idle_valid", fetch_valid, 0);
    chk("idle_instr", fetch_instr, NOP);

    // Short program load with ld_last on the third word
    ws = '{32'h0000_2083, 32'h0040_2103, 32'h4020_81B3};
    load(ws, 1'b1, 0, 1'b0, "ld3");

    tbl = '{
      '{32'h0000_0008,           32'h4020_81B3, 1'b0},
      '{32'h0000_000C,           NOP,           1'b0},
      '{32'h0000_0000,           32'h0000_2083, 1'b0},
      '{32'h0000_0004,           32'h0040_2103, 1'b0},
      '{32'h0000_0006,           NOP,           1'b1},
      '{32'h0000_0001,           NOP,           1'b1},
      '{32'(4 * DEPTH),          NOP,           1'b1},
      '{32'(4 * DEPTH - 4),      NOP,           1'b0},
      '{32'hFFFF_FFFC,           NOP,           1'b1}
    };
    foreach (tbl[i]) do_fetch(tbl[i].pc, tbl[i].instr, tbl[i].fault, $sformatf("tbl%0d", i));

    // Full-depth load without ld_last; extra ld_valid after the end must be ignored
    ws.delete();
    for (int i = 0; i < DEPTH; i++) ws.push_back($urandom);
    load(ws, 1'b0, 3, 1'b0, "full");
    verify_all("full_rd");

    // Random fetch addresses against the model
    for (int k = 0; k < 40; k++) begin
      r   = $urandom_range(0, 9);
      idx = $urandom_range(0, DEPTH - 1);
      if (r < 6)       a = 32'(idx * 4);
      else if (r < 8)  a = 32'(idx * 4 + $urandom_range(1, 3));
      else if (r < 9)  a = 32'(4 * DEPTH + 4 * $urandom_range(0, 1000));
      else             a = $urandom;
      model_check(a, $sformatf("rnd_fetch%0d", k));
    end

    // Random-length loads with gaps between words
    for (int t = 0; t < 2; t++) begin
      n = $urandom_range(1, DEPTH);
      ws.delete();
      for (int i = 0; i < n; i++) ws.push_back($urandom);
      load(ws, 1'b1, 0, 1'b1, $sformatf("rld%0d", t));
      verify_all($sformatf("rld%0d_rd", t));
    end

    // ld_start together with a fetch: fetch sees old contents, state goes to LOAD
    fetch_req = 1'b1; pc = 32'h8; ld_start = 1'b1;
    step();
    fetch_req = 1'b0; ld_start = 1'b0;
    chk("same_valid", fetch_valid, 1);
    chk("same_instr", fetch_instr, mdl[2]);
    chk("same_fault", fetch_fault, 0);
    chk("same_ready", ld_ready, 1);
    chk("same_busy",  busy, 1);

    // Fetch while loading is dropped
    fetch_req = 1'b1; pc = 32'h0;
    step();
    fetch_req = 1'b0;
    chk("ldfetch_valid", fetch_valid, 0);
    chk("ldfetch_instr", fetch_instr, NOP);
    chk("ldfetch_fault", fetch_fault, 0);

    // Five words in, then reset mid-load: everything is refilled with NOP
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = $urandom;
      step();
    end
    ld_valid = 1'b0;
    #2;
    do_reset("midld");
    do_fetch(32'h0, NOP, 1'b0, "midld_pc0");
    verify_all("midld_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_inst_mem.md
PROG_INST_MEM -- requirements
Module: prog_inst_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, meaning number of words; power of two, 4..4096.
REQ-003 SHALL have parameter NOP_WORD, default 32'h0000_0013, meaning fill and fault word (addi x0,x0,0).
REQ-004 SHALL have port clk input 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-006 SHALL have port pc input 32: fetch byte address.
REQ-007 SHALL have port fetch_req input 1: fetch request, sampled each cycle.
REQ-008 SHALL have port fetch_valid output 1: fetch_instr/fetch_fault valid this cycle.
REQ-009 SHALL have port fetch_instr output DATA_W: fetched instruction.
REQ-010 SHALL have port fetch_fault output 1: fetched pc misaligned or out of range.
REQ-011 SHALL have port ld_start input 1: begin program load at word 0.
REQ-012 SHALL have port ld_valid input 1: ld_data holds a word.
REQ-013 SHALL have port ld_data input DATA_W: load word.
REQ-014 SHALL have port ld_last input 1: qualifies the final load word.
REQ-015 SHALL have port ld_ready output 1: accepting load words.
REQ-016 SHALL have port ld_done output 1: one-cycle pulse when load plus fill is complete.
REQ-017 SHALL have port busy output 1: high in any state except RUN.

Function
REQ-018 SHALL implement states FILL, RUN and LOAD.
REQ-019 FILL SHALL write NOP_WORD to mem[fill_ptr] each cycle, incrementing fill_ptr; it SHALL go to RUN after writing word DEPTH-1.
REQ-020 In RUN, ld_start SHALL go to LOAD with load pointer 0; ld_start SHALL be ignored in FILL and LOAD.
REQ-021 ld_ready SHALL be 1 exactly while in LOAD; a word SHALL be written only when ld_valid && ld_ready, then pointer+1.
REQ-022 A write with ld_last=1 at pointer p<DEPTH-1 SHALL go to FILL with fill_ptr=p+1.
REQ-023 A write at pointer DEPTH-1 SHALL end the load regardless of ld_last, going directly to RUN; excess words are never accepted.
REQ-024 ld_done SHALL pulse for one cycle on the FILL->RUN or LOAD->RUN transition that ends a load, but not after the post-reset fill.
REQ-025 Fetch latency SHALL be 1: fetch_req=1 in RUN at cycle N gives fetch_valid=1 at N+1 with the read data for the pc sampled at N.
REQ-026 Word index SHALL be pc[log2(DEPTH)+1:2].
REQ-027 If pc[1:0]!=0 or pc>>2 >= DEPTH, the response SHALL be fetch_fault=1 and fetch_instr=NOP_WORD.
REQ-028 fetch_req outside RUN SHALL be dropped: fetch_valid=0 next cycle; no queuing.
REQ-029 fetch_req and ld_start in the same RUN cycle SHALL both take effect: the fetch returns old contents at N+1 and the state becomes LOAD.
REQ-030 When fetch_valid=0, fetch_instr SHALL hold NOP_WORD and fetch_fault SHALL be 0.
REQ-031 The memory array SHALL be written only by FILL or LOAD, one write per cycle maximum.

Reset
REQ-032 rst_n low SHALL immediately force state FILL, fill_ptr=0, load pointer 0, fetch_valid=0, fetch_fault=0, fetch_instr=NOP_WORD, ld_ready=0, ld_done=0 and busy=1.
REQ-033 Reset mid-LOAD or mid-FILL SHALL abandon the operation; the post-reset FILL overwrites all DEPTH words.
REQ-034 The memory array itself SHALL have no reset; it is initialised only by FILL.

Structure
REQ-035 A shared package SHALL hold the state enum (FILL/RUN/LOAD), NOP_WORD and the fault-reason constants.
REQ-036 The storage array SHALL be one sub-module, inst_ram_1r1w: single write port plus synchronous read port, DEPTH x DATA_W.
REQ-037 The FSM, pointers and fault logic SHALL reside in prog_inst_mem.

Verification
REQ-038 Post-reset: after rst_n rises, busy=1 for exactly DEPTH cycles, then a fetch of pc=0x0 -> fetch_instr=0x00000013, fetch_valid=1 one cycle later, no ld_done.
REQ-039 Load 3 words 0x00002083, 0x00402103, 0x402081B3 with ld_last on the third -> ld_done after DEPTH-3 fill cycles; pc 0x8 -> 0x402081B3; pc 0xC -> 0x00000013.
REQ-040 Fault: pc=0x6 -> fetch_fault=1 and NOP_WORD; pc=4*DEPTH -> fetch_fault=1.
REQ-041 Full load: DEPTH words without ld_last -> ld_ready drops after word DEPTH-1, ld_done next cycle, no FILL cycles; extra ld_valid ignored.
REQ-042 ld_start and fetch_req in the same cycle -> fetch returns old word; fetch_req during LOAD -> fetch_valid=0.
REQ-043 rst_n pulsed low mid-LOAD (after 5 words) -> outputs at reset values immediately; after refill, pc 0x0 reads 0x00000013.
